fpu_addsub_arbiter: RTL

- Shares one fixed-latency FP32 add/sub datapath (unpack, align, add, normalization/rounding) between two requesters.
- Round-robin arbitration; accepts one operation at a time; launches it with a start pulse; counts the datapath latency; captures result and flags; returns them to the owning requester over a valid/ready response.
- Sits between issue logic and the shared FPU add/sub pipeline; exactly one operation in flight.

---
 rtl/fpu_addsub_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 add/sub datapath between two requesters.
// Optional per-requester completion counters are enabled with `define FPU_ARB_PERF_CNT_EN.
module fpu_addsub_arbiter #(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [63:0]      req_a,
   input  logic [63:0]      req_b,
   input  logic [1:0]       req_sub,
   output logic             dp_start,
   output logic [31:0]      dp_a,
   output logic [31:0]      dp_b,
   output logic             dp_sub,
   input  logic [31:0]      dp_result,
   input  logic [2:0]       dp_flags,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [31:0]      resp_data,
   output logic [2:0]       resp_flags,
   output logic             busy,
   output logic [CNT_W-1:0] perf_cnt0,
   output logic [CNT_W-1:0] perf_cnt1
);

   localparam int unsigned OP_W   = 32;
   localparam int unsigned FLAG_W = 3;
   localparam int unsigned LCNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_accept;
   logic                w_capture;
   logic                w_handshake;
   logic                w_gnt;
   logic [OP_W-1:0]     w_sel_a;
   logic [OP_W-1:0]     w_sel_b;
   logic                w_sel_sub;

   logic                r_prio;
   logic                r_owner;
   logic [LCNT_W-1:0]   r_cnt;
   logic                r_dp_start;
   logic [OP_W-1:0]     r_dp_a;
   logic [OP_W-1:0]     r_dp_b;
   logic                r_dp_sub;
   logic [1:0]          r_resp_valid;
   logic [OP_W-1:0]     r_resp_data;
   logic [FLAG_W-1:0]   r_resp_flags;
   logic                r_busy;

   // Operand mux for the granted requester
   assign w_sel_a   = w_gnt ? req_a[63:32] : req_a[31:0];
   assign w_sel_b   = w_gnt ? req_b[63:32] : req_b[31:0];
   assign w_sel_sub = w_gnt ? req_sub[1]   : req_sub[0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_handshake  = 1'b0;
      req_ready    = 2'b00;
      // Priority holder wins only on contention; a lone requester is always granted
      w_gnt        = (&req_valid) ? r_prio : req_valid[1];
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_accept         = 1'b1;
               req_ready[w_gnt] = 1'b1;
               w_next_state     = S_START;
            end
         end
         S_START: w_next_state = S_WAIT;
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_capture    = 1'b1;
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready[r_owner]) begin
               w_handshake  = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio       <= 1'b0;
         r_owner      <= 1'b0;
         r_cnt        <= '0;
         r_dp_start   <= 1'b0;
         r_dp_a       <= '0;
         r_dp_b       <= '0;
         r_dp_sub     <= 1'b0;
         r_resp_valid <= 2'b00;
         r_resp_data  <= '0;
         r_resp_flags <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_dp_start <= w_accept;
         if (w_accept) begin
            r_dp_a   <= w_sel_a;
            r_dp_b   <= w_sel_b;
            r_dp_sub <= w_sel_sub;
            r_owner  <= w_gnt;
            r_busy   <= 1'b1;
         end
         // Down-counter spans exactly LATENCY cycles of WAIT
         if (r_state == S_START)
            r_cnt <= LCNT_W'(LATENCY - 1);
         else if (r_state == S_WAIT && r_cnt != '0)
            r_cnt <= r_cnt - LCNT_W'(1);
         if (w_capture) begin
            r_resp_data  <= dp_result;
            r_resp_flags <= dp_flags;
            r_resp_valid <= r_owner ? 2'b10 : 2'b01;
         end
         if (w_handshake) begin
            r_resp_valid <= 2'b00;
            r_prio       <= ~r_owner;
            r_busy       <= 1'b0;
         end
      end
   end

`ifdef FPU_ARB_PERF_CNT_EN
   logic [CNT_W-1:0] r_perf0;
   logic [CNT_W-1:0] r_perf1;

   // Saturating completion counters, bumped on response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf0 <= '0;
         r_perf1 <= '0;
      end else if (w_handshake) begin
         if (!r_owner && r_perf0 != '1) r_perf0 <= r_perf0 + CNT_W'(1);
         if (r_owner && r_perf1 != '1)  r_perf1 <= r_perf1 + CNT_W'(1);
      end
   end

   assign perf_cnt0 = r_perf0;
   assign perf_cnt1 = r_perf1;
`else
   assign perf_cnt0 = '0;
   assign perf_cnt1 = '0;
`endif

   assign dp_start   = r_dp_start;
   assign dp_a       = r_dp_a;
   assign dp_b       = r_dp_b;
   assign dp_sub     = r_dp_sub;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_flags = r_resp_flags;
   assign busy       = r_busy;

endmodule
